access_checker: RTL and testbench

ACCESS_CHECKER -- requirements
Module: access_checker

---
 rtl/access_pkg.sv | 37 +++
 rtl/access_checker_rise_detect.sv | 25 ++
 rtl/access_checker.sv | 145 ++++++++++++++
 tb/tb_access_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_pkg.sv
// Shared types and constants for the access checker: FSM states, digit and
// user-record types, the built-in user table and the master password.
package access_pkg;

  typedef enum logic [2:0] {
    ID_ENTRY   = 3'd0,
    ID_CHECK   = 3'd1,
    PASS_ENTRY = 3'd2,
    PASS_CHECK = 3'd3,
    GRANTED    = 3'd4,
    LOCKED     = 3'd5
  } state_t;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] pass;
  } user_rec_t;

  localparam int TABLE_DEPTH = 8;

  // Words are written digit4..digit1, i.e. first-entered digit in the top nibble.
  localparam user_rec_t USER_TABLE [TABLE_DEPTH] = '{
    '{id: 16'h1234, pass: 16'h4321},
    '{id: 16'hABCD, pass: 16'h0000},
    '{id: 16'h0007, pass: 16'hF00F},
    '{id: 16'h9876, pass: 16'h2468},
    '{id: 16'h1111, pass: 16'h1357},
    '{id: 16'h2222, pass: 16'h8642},
    '{id: 16'h3333, pass: 16'hC0DE},
    '{id: 16'h4444, pass: 16'hBEEF}
  };

  localparam logic [15:0] MASTER_PASS = 16'h9999;

endpackage

// File: rtl/access_checker_rise_detect.sv
// Registered rising-edge pulse; the armed bit keeps an input that is already
// high at reset release from being seen as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pulse
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      prev_q  <= en;
      armed_q <= 1'b1;
      pulse   <= armed_q & en & ~prev_q;
    end
  end

endmodule

// File: rtl/access_checker.sv
// Keypad access checker: 4-digit ID lookup, 4-digit password check with
// lockout. Optional build macro ACCESS_MASTER_PASS_EN also accepts 9-9-9-9.
module access_checker
  import access_pkg::*;
#(
  parameter int NUM_USERS    = 4,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enableSetUserIDFlag,
  input  logic       enableSetPassFlag,
  input  logic [3:0] digitIn,
  output logic       userIDfoundFlag,
  output logic       accessFlag,
  output logic       blinkFlag,
  output logic       outOfAttemptsFlag,
  output logic [3:0] userID_digit1,
  output logic [3:0] userID_digit2,
  output logic [3:0] userID_digit3,
  output logic [3:0] userID_digit4,
  output logic [2:0] userIndex,
  output state_t     state_dbg
);

  localparam logic [2:0] MAX_ATT = 3'(MAX_ATTEMPTS);

  state_t      state;
  logic [1:0]  digit_cnt;
  logic [15:0] pass_word;
  logic [2:0]  attempts;
  logic [2:0]  attempts_next;
  logic        id_pulse;
  logic        pass_pulse;
  logic        id_hit;
  logic [2:0]  id_idx;
  logic        pass_ok;
  logic [15:0] id_word;

  rise_detect u_id_rise (
    .clk   (clk),
    .rst   (rst),
    .en    (enableSetUserIDFlag),
    .pulse (id_pulse)
  );

  rise_detect u_pass_rise (
    .clk   (clk),
    .rst   (rst),
    .en    (enableSetPassFlag),
    .pulse (pass_pulse)
  );

  assign id_word   = {userID_digit4, userID_digit3, userID_digit2, userID_digit1};
  assign state_dbg = state;

  // Lowest matching table index wins if IDs were ever duplicated.
  always_comb begin
    id_hit = 1'b0;
    id_idx = 3'd0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (!id_hit && id_word == USER_TABLE[i].id) begin
        id_hit = 1'b1;
        id_idx = 3'(i);
      end
    end
  end

  always_comb begin
    pass_ok = (pass_word == USER_TABLE[userIndex].pass);
`ifdef ACCESS_MASTER_PASS_EN
    if (pass_word == MASTER_PASS) pass_ok = 1'b1;
`endif
  end

  assign attempts_next = (attempts < MAX_ATT) ? attempts + 3'd1 : attempts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ID_ENTRY;
      digit_cnt         <= 2'd0;
      pass_word         <= 16'd0;
      attempts          <= 3'd0;
      userIDfoundFlag   <= 1'b0;
      accessFlag        <= 1'b0;
      blinkFlag         <= 1'b0;
      outOfAttemptsFlag <= 1'b0;
      userID_digit1     <= 4'd0;
      userID_digit2     <= 4'd0;
      userID_digit3     <= 4'd0;
      userID_digit4     <= 4'd0;
      userIndex         <= 3'd0;
    end else begin
      blinkFlag <= 1'b0;
      case (state)
        ID_ENTRY: begin
          if (id_pulse) begin
            userID_digit4 <= userID_digit3;
            userID_digit3 <= userID_digit2;
            userID_digit2 <= userID_digit1;
            userID_digit1 <= digitIn;
            digit_cnt     <= digit_cnt + 2'd1;
            if (digit_cnt == 2'd3) state <= ID_CHECK;
          end
        end
        ID_CHECK: begin
          digit_cnt <= 2'd0;
          if (id_hit) begin
            userIDfoundFlag <= 1'b1;
            userIndex       <= id_idx;
            state           <= PASS_ENTRY;
          end else begin
            state <= ID_ENTRY;
          end
        end
        PASS_ENTRY: begin
          if (pass_pulse) begin
            pass_word <= {pass_word[11:0], digitIn};
            digit_cnt <= digit_cnt + 2'd1;
            if (digit_cnt == 2'd3) state <= PASS_CHECK;
          end
        end
        PASS_CHECK: begin
          digit_cnt <= 2'd0;
          pass_word <= 16'd0;
          if (pass_ok) begin
            accessFlag <= 1'b1;
            state      <= GRANTED;
          end else begin
            blinkFlag <= 1'b1;
            attempts  <= attempts_next;
            if (attempts_next == MAX_ATT) begin
              outOfAttemptsFlag <= 1'b1;
              state             <= LOCKED;
            end else begin
              state <= PASS_ENTRY;
            end
          end
        end
        default: ;  // GRANTED and LOCKED hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_access_checker.sv
// Directed and randomized bench for access_checker with a table-driven
// reference model of ID lookup, password acceptance and lockout.
module tb_access_checker;
  import access_pkg::*;

  localparam int NUM_USERS    = 4;
  localparam int MAX_ATTEMPTS = 3;
`ifdef ACCESS_MASTER_PASS_EN
  localparam bit MASTER = 1'b1;
`else
  localparam bit MASTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enableSetUserIDFlag = 1'b0;
  logic       enableSetPassFlag = 1'b0;
  logic [3:0] digitIn = 4'd0;
  logic       userIDfoundFlag, accessFlag, blinkFlag, outOfAttemptsFlag;
  logic [3:0] userID_digit1, userID_digit2, userID_digit3, userID_digit4;
  logic [2:0] userIndex;
  state_t     state_dbg;

  int tests = 0;
  int fails = 0;
  int blink_hi = 0;
  int blink_rises = 0;

  access_checker #(.NUM_USERS(NUM_USERS), .MAX_ATTEMPTS(MAX_ATTEMPTS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enableSetUserIDFlag (enableSetUserIDFlag),
    .enableSetPassFlag   (enableSetPassFlag),
    .digitIn             (digitIn),
    .userIDfoundFlag     (userIDfoundFlag),
    .accessFlag          (accessFlag),
    .blinkFlag           (blinkFlag),
    .outOfAttemptsFlag   (outOfAttemptsFlag),
    .userID_digit1       (userID_digit1),
    .userID_digit2       (userID_digit2),
    .userID_digit3       (userID_digit3),
    .userID_digit4       (userID_digit4),
    .userIndex           (userIndex),
    .state_dbg           (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  // Blink monitor: total high samples and rising edges
  always @(negedge clk) begin : blink_mon
    logic prev;
    if (blinkFlag) blink_hi++;
    if (blinkFlag && !prev) blink_rises++;
    prev = blinkFlag;
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int user_of(input logic [15:0] id);
    for (int i = 0; i < NUM_USERS; i++)
      if (USER_TABLE[i].id == id) return i;
    return -1;
  endfunction

  function automatic bit accepted(input int u, input logic [15:0] pw);
    return (pw == USER_TABLE[u].pass) || (MASTER && pw == MASTER_PASS);
  endfunction

  // Driver tasks (entered and left at a negedge)
  task automatic press(input logic [3:0] d, input bit id_en, input bit pass_en);
    digitIn = d;
    enableSetUserIDFlag = id_en;
    enableSetPassFlag = pass_en;
    repeat (3) @(negedge clk);
    enableSetUserIDFlag = 1'b0;
    enableSetPassFlag = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_id(input logic [15:0] w);
    for (int k = 3; k >= 0; k--) press(w[k*4 +: 4], 1'b1, 1'b0);
  endtask

  task automatic enter_pass(input logic [15:0] w);
    for (int k = 3; k >= 0; k--) press(w[k*4 +: 4], 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_found"}, 32'(userIDfoundFlag), 32'd0);
    check({tag, "_access"}, 32'(accessFlag), 32'd0);
    check({tag, "_blink"}, 32'(blinkFlag), 32'd0);
    check({tag, "_locked"}, 32'(outOfAttemptsFlag), 32'd0);
    check({tag, "_digits"}, 32'({userID_digit4, userID_digit3, userID_digit2, userID_digit1}), 32'd0);
    check({tag, "_index"}, 32'(userIndex), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ID_ENTRY));
  endtask

  function automatic logic [15:0] shown_id();
    return {userID_digit4, userID_digit3, userID_digit2, userID_digit1};
  endfunction

  initial begin
    int b_rise0, b_hi0;
    int exp_u, n_fail, n_try;
    bit done, granted;
    logic [15:0] id, pw;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    // ID 1-2-3-4 with both enables on the first digit; timing of the 4th digit
    b_rise0 = blink_rises;
    press(4'd1, 1'b1, 1'b1);
    press(4'd2, 1'b1, 1'b0);
    press(4'd3, 1'b1, 1'b0);
    digitIn = 4'd4;
    enableSetUserIDFlag = 1'b1;
    @(negedge clk);
    check("id_t1_found", 32'(userIDfoundFlag), 32'd0);
    @(negedge clk);
    check("id_t2_found", 32'(userIDfoundFlag), 32'd0);
    check("id_t2_digit1", 32'(userID_digit1), 32'd4);
    @(negedge clk);
    check("id_t3_found", 32'(userIDfoundFlag), 32'd1);
    enableSetUserIDFlag = 1'b0;
    repeat (2) @(negedge clk);
    check("id_index", 32'(userIndex), 32'd0);
    check("id_digits", 32'(shown_id()), 32'h1234);
    check("id_state", 32'(state_dbg), 32'(PASS_ENTRY));

    // Correct password, first digit with both enables; terminal afterwards
    press(4'd4, 1'b1, 1'b1);
    press(4'd3, 1'b0, 1'b1);
    press(4'd2, 1'b0, 1'b1);
    press(4'd1, 1'b0, 1'b1);
    check("grant_access", 32'(accessFlag), 32'd1);
    check("grant_digits", 32'(shown_id()), 32'h1234);
    enter_id(16'h5678);
    enter_pass(16'h0000);
    check("grant_hold_access", 32'(accessFlag), 32'd1);
    check("grant_hold_digits", 32'(shown_id()), 32'h1234);
    check("grant_state", 32'(state_dbg), 32'(GRANTED));
    check("grant_no_blink", 32'(blink_rises - b_rise0), 32'd0);

    // Held enable loads one digit
    do_reset();
    digitIn = 4'd5;
    enableSetUserIDFlag = 1'b1;
    repeat (50) @(negedge clk);
    enableSetUserIDFlag = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_digits", 32'(shown_id()), 32'h0005);

    // Enable high across reset release is not an event
    digitIn = 4'd7;
    enableSetUserIDFlag = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    enableSetUserIDFlag = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_digits", 32'(shown_id()), 32'h0000);
    press(4'd8, 1'b1, 1'b0);
    check("rel_next", 32'(shown_id()), 32'h0008);

    // Lockout after MAX_ATTEMPTS wrong passwords
    do_reset();
    b_rise0 = blink_rises;
    b_hi0 = blink_hi;
    enter_id(16'hABCD);
    check("lk_found", 32'(userIDfoundFlag), 32'd1);
    check("lk_index", 32'(userIndex), 32'd1);
    enter_pass(16'h1111);
    enter_pass(16'h2222);
    check("lk_two_locked", 32'(outOfAttemptsFlag), 32'd0);
    check("lk_two_rises", 32'(blink_rises - b_rise0), 32'd2);
    enter_pass(16'h3333);
    check("lk_rises", 32'(blink_rises - b_rise0), 32'd3);
    check("lk_width", 32'(blink_hi - b_hi0), 32'd3);
    check("lk_locked", 32'(outOfAttemptsFlag), 32'd1);
    enter_pass(16'h0000);
    check("lk_access", 32'(accessFlag), 32'd0);
    check("lk_state", 32'(state_dbg), 32'(LOCKED));

    // Asynchronous reset mid-password
    do_reset();
    enter_id(16'h9876);
    press(4'd2, 1'b0, 1'b1);
    press(4'd4, 1'b0, 1'b1);
    check("ar_found_before", 32'(userIDfoundFlag), 32'd1);
    #2 rst = 1'b0;
    #1 check_idle("ar");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    enter_id(16'h9876);
    check("ar_found", 32'(userIDfoundFlag), 32'd1);
    check("ar_index", 32'(userIndex), 32'd3);
    enter_pass(16'h2468);
    check("ar_access", 32'(accessFlag), 32'd1);

    // 9-9-9-9 password
    do_reset();
    b_rise0 = blink_rises;
    enter_id(16'h1234);
    enter_pass(16'h9999);
    check("mp_access", 32'(accessFlag), 32'(MASTER));
    check("mp_blink", 32'(blink_rises - b_rise0), 32'(!MASTER));

    // Unknown ID then a valid one
    do_reset();
    enter_id(16'h0000);
    check("bad_found", 32'(userIDfoundFlag), 32'd0);
    check("bad_state", 32'(state_dbg), 32'(ID_ENTRY));
    enter_id(16'h0007);
    check("bad_then_found", 32'(userIDfoundFlag), 32'd1);
    check("bad_then_index", 32'(userIndex), 32'd2);

    // Randomized sessions against the model
    for (int it = 0; it < 12; it++) begin
      do_reset();
      b_rise0 = blink_rises;
      b_hi0 = blink_hi;
      if ($urandom_range(0, 2) != 0) id = USER_TABLE[$urandom_range(0, NUM_USERS - 1)].id;
      else id = 16'($urandom);
      exp_u = user_of(id);
      enter_id(id);
      check("rnd_digits", 32'(shown_id()), 32'(id));
      check("rnd_found", 32'(userIDfoundFlag), 32'(exp_u >= 0));
      n_fail = 0;
      done = 1'b0;
      granted = 1'b0;
      if (exp_u >= 0) begin
        check("rnd_index", 32'(userIndex), 32'(exp_u));
        n_try = $urandom_range(1, 4);
        for (int a = 0; a < n_try; a++) begin
          case ($urandom_range(0, 3))
            0: pw = USER_TABLE[exp_u].pass;
            1: pw = MASTER_PASS;
            default: pw = 16'($urandom);
          endcase
          if (!done) begin
            if (accepted(exp_u, pw)) begin
              granted = 1'b1;
              done = 1'b1;
            end else begin
              n_fail++;
              if (n_fail == MAX_ATTEMPTS) done = 1'b1;
            end
          end
          enter_pass(pw);
        end
      end
      check("rnd_access", 32'(accessFlag), 32'(granted));
      check("rnd_locked", 32'(outOfAttemptsFlag), 32'(n_fail == MAX_ATTEMPTS));
      check("rnd_blinks", 32'(blink_rises - b_rise0), 32'(n_fail));
      check("rnd_blink_w", 32'(blink_hi - b_hi0), 32'(n_fail));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
